// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and signed-overflow helper shared by alu_seq.
package alu_pkg;

    localparam int unsigned OpWidth = 5;

    localparam logic [OpWidth-1:0] OpAdd = 5'd1;
    localparam logic [OpWidth-1:0] OpSub = 5'd2;
    localparam logic [OpWidth-1:0] OpLsr = 5'd3;
    localparam logic [OpWidth-1:0] OpLsl = 5'd4;
    localparam logic [OpWidth-1:0] OpRsr = 5'd5;
    localparam logic [OpWidth-1:0] OpRsl = 5'd6;
    localparam logic [OpWidth-1:0] OpMul = 5'd7;
    localparam logic [OpWidth-1:0] OpDiv = 5'd8;
    localparam logic [OpWidth-1:0] OpMod = 5'd9;
    localparam logic [OpWidth-1:0] OpAnd = 5'd10;
    localparam logic [OpWidth-1:0] OpOr  = 5'd11;
    localparam logic [OpWidth-1:0] OpXor = 5'd12;
    localparam logic [OpWidth-1:0] OpNot = 5'd13;
    localparam logic [OpWidth-1:0] OpCmp = 5'd14;
    localparam logic [OpWidth-1:0] OpTst = 5'd15;
    localparam logic [OpWidth-1:0] OpInc = 5'd16;
    localparam logic [OpWidth-1:0] OpDec = 5'd17;
    localparam logic [OpWidth-1:0] OpNop = 5'd31;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    // Takes operand/result sign bits only, so it works for any WIDTH.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr,
                                        input logic sub);
        return sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between a datapath master and the alu_seq slave.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    import alu_pkg::*;

    logic               i_bgn;
    logic [OpWidth-1:0] i_opcode;
    logic [WIDTH-1:0]   i_a;
    logic [WIDTH-1:0]   i_b;
    logic [WIDTH-1:0]   o_acc1;
    logic [WIDTH-1:0]   o_acc2;
    logic               o_zero;
    logic               o_negative;
    logic               o_carry;
    logic               o_overflow;
    logic               o_rdy;
    logic               o_busy;

    modport master (
        output i_bgn, i_opcode, i_a, i_b,
        input  o_acc1, o_acc2, o_zero, o_negative, o_carry, o_overflow, o_rdy, o_busy
    );

    modport slave (
        input  i_bgn, i_opcode, i_a, i_b,
        output o_acc1, o_acc2, o_zero, o_negative, o_carry, o_overflow, o_rdy, o_busy
    );

endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Only instantiated by alu_seq when ALU_MULDIV_EN is defined.
module alu_muldiv_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH:0]   w_sum, w_shift, w_diff;

    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, r_opnd};
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_opnd};
    end

    // Mul: r_lo holds the multiplier, r_hi the partial product high word.
    // Div: r_lo shifts the dividend out and the quotient in, r_hi is the remainder.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_hi   <= '0;
            r_lo   <= i_div ? i_a : i_b;
            r_opnd <= i_div ? i_b : i_a;
            r_div  <= i_div;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_div) begin
                if (!w_diff[WIDTH]) begin
                    r_hi <= w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else if (r_lo[0]) begin
                {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end else begin
                {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
            end
        end
    end

    // High while the final iteration is in flight; results are complete after this edge.
    assign o_done = (r_cnt == CNT_W'(1));
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with bgn/rdy handshake: FSM, single-cycle datapath, rotator and flags.
// Define ALU_MULDIV_EN to include the iterative MUL/DIV/MOD engine.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic       i_clk,
    input logic       i_rst_n,
    alu_seq_if.slave  io_bus
);
    localparam int unsigned ShW = $clog2(WIDTH);

    state_e             r_state;
    logic [OpWidth-1:0] r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_rot, r_acc1, r_acc2;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_zero, r_negative, r_carry, r_overflow, r_rdy, r_busy;

    logic               w_accept, w_rot_in, w_go_exec, w_rot_op;
    logic [ShW-1:0]     w_k;
    logic [WIDTH-1:0]   w_opb, w_res1, w_res2;
    logic [WIDTH:0]     w_sum, w_diff;
    logic               w_carry, w_ovf, w_wr_acc, w_wr_flg, w_hi_neg, w_shift_big;

    assign w_accept = (r_state == StIdle) && io_bus.i_bgn;
    assign w_rot_in = (io_bus.i_opcode == OpRsr) || (io_bus.i_opcode == OpRsl);
    assign w_k      = io_bus.i_b[ShW-1:0];
    assign w_rot_op = (r_op == OpRsr) || (r_op == OpRsl);

`ifdef ALU_MULDIV_EN
    logic             w_md_in, w_md_start, w_md_done;
    logic [WIDTH-1:0] w_md_hi, w_md_lo;

    assign w_md_in = (io_bus.i_opcode == OpMul) || (io_bus.i_opcode == OpDiv) ||
                     (io_bus.i_opcode == OpMod);
    // Divide by zero skips the engine and is resolved directly in DONE.
    assign w_md_start = w_accept && w_md_in &&
                        !((io_bus.i_opcode != OpMul) && (io_bus.i_b == '0));
    assign w_go_exec  = (w_rot_in && (w_k != '0)) || w_md_start;

    alu_muldiv_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_md_start),
        .i_div   (io_bus.i_opcode != OpMul),
        .i_a     (io_bus.i_a),
        .i_b     (io_bus.i_b),
        .o_done  (w_md_done),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo)
    );
`else
    assign w_go_exec = w_rot_in && (w_k != '0);
`endif

    always_comb begin
        w_opb       = ((r_op == OpInc) || (r_op == OpDec)) ? WIDTH'(1) : r_b;
        w_sum       = {1'b0, r_a} + {1'b0, w_opb};
        w_diff      = {1'b0, r_a} - {1'b0, w_opb};
        w_shift_big = |r_b[WIDTH-1:ShW];
        w_res1      = r_acc1;
        w_res2      = '0;
        w_carry     = 1'b0;
        w_ovf       = 1'b0;
        w_wr_acc    = 1'b1;
        w_wr_flg    = 1'b1;
        w_hi_neg    = 1'b0;
        case (r_op)
            OpAdd, OpInc: begin
                w_res1  = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = signed_ovf(r_a[WIDTH-1], w_opb[WIDTH-1], w_sum[WIDTH-1], 1'b0);
            end
            OpSub, OpDec, OpCmp: begin
                w_res1   = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = signed_ovf(r_a[WIDTH-1], w_opb[WIDTH-1], w_diff[WIDTH-1], 1'b1);
                w_wr_acc = (r_op != OpCmp);
            end
            OpAnd, OpTst: begin
                w_res1   = r_a & r_b;
                w_wr_acc = (r_op != OpTst);
            end
            OpOr:  w_res1 = r_a | r_b;
            OpXor: w_res1 = r_a ^ r_b;
            OpNot: w_res1 = ~r_a;
            OpLsl: w_res1 = w_shift_big ? '0 : (r_a << r_b[ShW-1:0]);
            OpLsr: w_res1 = w_shift_big ? '0 : (r_a >> r_b[ShW-1:0]);
            OpRsr, OpRsl: w_res1 = r_rot;
`ifdef ALU_MULDIV_EN
            OpMul: begin
                w_res1   = w_md_lo;
                w_res2   = w_md_hi;
                w_hi_neg = 1'b1;
            end
            OpDiv, OpMod: begin
                if (r_b == '0) begin
                    w_res1   = '1;
                    w_res2   = r_a;
                    w_ovf    = 1'b1;
                    w_hi_neg = 1'b1;
                end else if (r_op == OpDiv) begin
                    w_res1   = w_md_lo;
                    w_res2   = w_md_hi;
                    w_hi_neg = 1'b1;
                end else begin
                    w_res1 = w_md_hi;
                end
            end
`endif
            default: begin
                w_wr_acc = 1'b0;
                w_wr_flg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rot      <= '0;
            r_cnt      <= '0;
            r_acc1     <= '0;
            r_acc2     <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_rdy      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op    <= io_bus.i_opcode;
                        r_a     <= io_bus.i_a;
                        r_b     <= io_bus.i_b;
                        r_rot   <= io_bus.i_a;
                        r_cnt   <= CNT_W'(w_k);
                        r_busy  <= 1'b1;
                        r_state <= w_go_exec ? StExec : StDone;
                    end
                end
                StExec: begin
                    if (w_rot_op) begin
                        r_rot <= (r_op == OpRsl) ? {r_rot[WIDTH-2:0], r_rot[WIDTH-1]}
                                                 : {r_rot[0], r_rot[WIDTH-1:1]};
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) r_state <= StDone;
                    end
`ifdef ALU_MULDIV_EN
                    else if (w_md_done) begin
                        r_state <= StDone;
                    end
`endif
                end
                StDone: begin
                    if (w_wr_acc) begin
                        r_acc1 <= w_res1;
                        r_acc2 <= w_res2;
                    end
                    if (w_wr_flg) begin
                        r_zero     <= (w_res1 == '0) && (w_res2 == '0);
                        r_negative <= w_hi_neg ? w_res2[WIDTH-1] : w_res1[WIDTH-1];
                        r_carry    <= w_carry;
                        r_overflow <= w_ovf;
                    end
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.o_acc1     = r_acc1;
    assign io_bus.o_acc2     = r_acc2;
    assign io_bus.o_zero     = r_zero;
    assign io_bus.o_negative = r_negative;
    assign io_bus.o_carry    = r_carry;
    assign io_bus.o_overflow = r_overflow;
    assign io_bus.o_rdy      = r_rdy;
    assign io_bus.o_busy     = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH=16); expectations follow ALU_MULDIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        int          edge_exp;
        logic [15:0] acc1;
        logic [15:0] acc2;
        logic [3:0]  flg;   // {zero, negative, carry, overflow}
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];
    exp_t m_e;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input string tag, input int edge_exp, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [3:0] ef);
        exp_t e;
        e.tag = tag;
        e.edge_exp = edge_exp;
        e.acc1 = e1;
        e.acc2 = e2;
        e.flg = ef;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            check({tag, ".timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic issue(input string tag, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int lat, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [3:0] ef);
        wait_idle(tag);
        bus.i_opcode = op;
        bus.i_a      = a;
        bus.i_b      = b;
        bus.i_bgn    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_bgn = 1'b0;
        push_exp(tag, cyc + lat, e1, e2, ef);
        check({tag, ".busy_on"}, 32'(bus.o_busy), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".acc1"}, 32'(bus.o_acc1), 32'd0);
        check({tag, ".acc2"}, 32'(bus.o_acc2), 32'd0);
        check({tag, ".flags"},
              32'({bus.o_zero, bus.o_negative, bus.o_carry, bus.o_overflow}), 32'd0);
        check({tag, ".rdy"}, 32'(bus.o_rdy), 32'd0);
        check({tag, ".busy"}, 32'(bus.o_busy), 32'd0);
    endtask

    // Scoreboard: every rdy pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (bus.o_rdy === 1'b1) begin
            if (q.size() == 0) begin
                check("rdy_spurious", 32'(bus.o_rdy), 32'd0);
            end else begin
                m_e = q.pop_front();
                check({m_e.tag, ".rdy_edge"}, 32'(cyc), 32'(m_e.edge_exp));
                check({m_e.tag, ".acc1"}, 32'(bus.o_acc1), 32'(m_e.acc1));
                check({m_e.tag, ".acc2"}, 32'(bus.o_acc2), 32'(m_e.acc2));
                check({m_e.tag, ".flags"},
                      32'({bus.o_zero, bus.o_negative, bus.o_carry, bus.o_overflow}),
                      32'(m_e.flg));
                check({m_e.tag, ".busy_off"}, 32'(bus.o_busy), 32'd0);
            end
        end
    end

    initial begin
        int t0;
        bus.i_bgn    = 1'b0;
        bus.i_opcode = '0;
        bus.i_a      = '0;
        bus.i_b      = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        issue("add_ovf", OpAdd, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 4'b0101);
        issue("sub_borrow", OpSub, 16'd3, 16'd5, 1, 16'hFFFE, 16'h0000, 4'b0110);
        issue("cmp_eq", OpCmp, 16'd5, 16'd5, 1, 16'hFFFE, 16'h0000, 4'b1000);
        issue("rsl_k4", OpRsl, 16'h8001, 16'd20, 5, 16'h0018, 16'h0000, 4'b0000);
        issue("rsr_k0", OpRsr, 16'h1234, 16'd0, 1, 16'h1234, 16'h0000, 4'b0000);
`ifdef ALU_MULDIV_EN
        issue("mul_max", OpMul, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 4'b0100);
        issue("div_100_7", OpDiv, 16'd100, 16'd7, 17, 16'd14, 16'd2, 4'b0000);
        issue("div_by0", OpDiv, 16'd100, 16'd0, 1, 16'hFFFF, 16'd100, 4'b0001);
`else
        issue("mul_nop", OpMul, 16'hFFFF, 16'hFFFF, 1, 16'h1234, 16'h0000, 4'b0000);
        issue("div_nop", OpDiv, 16'd100, 16'd7, 1, 16'h1234, 16'h0000, 4'b0000);
        issue("div0_nop", OpDiv, 16'd100, 16'd0, 1, 16'h1234, 16'h0000, 4'b0000);
`endif
        issue("lsl_4", OpLsl, 16'h0003, 16'd4, 1, 16'h0030, 16'h0000, 4'b0000);
        issue("lsr_16", OpLsr, 16'h8000, 16'd16, 1, 16'h0000, 16'h0000, 4'b1000);
        issue("xor", OpXor, 16'hF0F0, 16'hFFFF, 1, 16'h0F0F, 16'h0000, 4'b0000);
        issue("inc_wrap", OpInc, 16'hFFFF, 16'h0000, 1, 16'h0000, 16'h0000, 4'b1010);
        issue("dec_ovf", OpDec, 16'h8000, 16'h0000, 1, 16'h7FFF, 16'h0000, 4'b0001);
        issue("tst_zero", OpTst, 16'h00F0, 16'h0F00, 1, 16'h7FFF, 16'h0000, 4'b1000);
        issue("nop", OpNop, 16'hAAAA, 16'h5555, 1, 16'h7FFF, 16'h0000, 4'b1000);
        issue("undef_op", 5'd20, 16'hAAAA, 16'h5555, 1, 16'h7FFF, 16'h0000, 4'b1000);
        issue("not", OpNot, 16'h00FF, 16'h0000, 1, 16'hFF00, 16'h0000, 4'b0100);

        // bgn held high: second op accepted one IDLE cycle after the first rdy.
        wait_idle("b2b");
        bus.i_opcode = OpAnd;
        bus.i_a      = 16'hFF00;
        bus.i_b      = 16'h0FF0;
        bus.i_bgn    = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        push_exp("b2b_and", t0 + 1, 16'h0F00, 16'h0000, 4'b0000);
        bus.i_opcode = OpOr;
        bus.i_a      = 16'h0001;
        bus.i_b      = 16'h0002;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.i_bgn = 1'b0;
        push_exp("b2b_or", t0 + 3, 16'h0003, 16'h0000, 4'b0000);

        // bgn pulsed mid-rotate must be ignored.
        issue("rsl_busy", OpRsl, 16'h0001, 16'd7, 8, 16'h0080, 16'h0000, 4'b0000);
        @(negedge clk);
        bus.i_opcode = OpAdd;
        bus.i_a      = 16'h0001;
        bus.i_b      = 16'h0001;
        bus.i_bgn    = 1'b1;
        @(negedge clk);
        bus.i_bgn = 1'b0;
        wait_idle("rsl_busy");
        repeat (5) @(negedge clk);

        // Reset in the fifth EXEC cycle abandons the op without a rdy.
        wait_idle("abort");
`ifdef ALU_MULDIV_EN
        bus.i_opcode = OpMul;
        bus.i_a      = 16'h1234;
        bus.i_b      = 16'h5678;
`else
        bus.i_opcode = OpRsl;
        bus.i_a      = 16'h0001;
        bus.i_b      = 16'd15;
`endif
        bus.i_bgn = 1'b1;
        @(posedge clk);
        #1;
        bus.i_bgn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("abort");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        wait_idle("end");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that replaces the fixed 16-bit ALU on the datapath. It uses a registered bgn/rdy handshake: operands and opcode are captured on start, executed in one or more cycles, and returned on acc1/acc2 with registered flags. Single-cycle ops finish in one cycle. Rotates, multiply and divide iterate one bit per cycle.

## Interface
- WIDTH, 16: operand and accumulator width; must be ≥4 and a power of two.
- CNT_W, $clog2(WIDTH)+1: width of the internal iteration counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bgn  in  1  start request; sampled only in IDLE.
- opcode  in  5  operation code (encodings listed under Structure).
- A, B  in  WIDTH  operands; captured on the accepted bgn edge.
- acc1  out  WIDTH  primary result (low half / quotient).
- acc2  out  WIDTH  secondary result (high half / remainder); 0 for single-width ops.
- zero, negative, carry, overflow  out  1  registered flags.
- rdy  out  1  one-cycle pulse when acc1/acc2/flags are updated.
- busy  out  1  high from accept until the cycle rdy is asserted.

## Operation
- States:
  - IDLE: bgn=1 latches A, B, opcode and moves to EXEC (iterative ops) or DONE (all others).
  - EXEC: iterates until the counter reaches 0, then moves to DONE.
  - DONE: writes results and flags, pulses rdy, returns to IDLE.
- While busy, bgn is ignored; no queuing.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR, NOT(A), INC(A+1), DEC(A-1).
  - LSR/LSL: logical shift by B; shift amount ≥ WIDTH yields 0.
- CMP and TST compute A-B and A&B respectively, update flags only, and leave acc1/acc2 unchanged.
- RSR/RSL rotate by k = B mod WIDTH, one position per EXEC cycle; k=0 goes straight to DONE with acc1=A.
- MUL: unsigned shift-add, WIDTH EXEC cycles; {acc2,acc1} = A*B.
- DIV/MOD: unsigned restoring division, WIDTH EXEC cycles.
  - DIV gives acc1=quotient, acc2=remainder.
  - MOD gives acc1=remainder, acc2=0.
- Divide by zero: skip EXEC; acc1 all-ones, acc2=A, overflow=1.
- NOP and undefined opcodes: DONE after one cycle; acc and flags unchanged.
- Flags, written only in DONE:
  - zero = (acc1==0 && acc2==0).
  - negative = MSB of the most significant result word.
  - ADD/INC: carry = unsigned carry-out; overflow = signed overflow.
  - SUB/CMP/DEC: carry = borrow (A<B unsigned); overflow = signed overflow.
  - All other ops: carry=0, overflow=0, except the divide-by-zero case above.
- Reset: state=IDLE; acc1, acc2, all flags, rdy and busy = 0. Reset during EXEC abandons the operation and produces no rdy.

## Timing
- bgn sampled high at edge N:
  - single-cycle ops: rdy=1 and results valid in the cycle after edge N+1.
  - rotate: after edge N+1+k.
  - MUL/DIV/MOD: after edge N+1+WIDTH.
- rdy is high for exactly one cycle. acc1, acc2 and flags hold until the next DONE.
- busy rises the cycle after edge N and falls together with the rdy pulse. The earliest next accept is the edge after rdy.
- bgn held high continuously issues back-to-back ops with one IDLE cycle between them.

## Configuration
- ALU_MULDIV_EN defined: MUL, DIV and MOD are implemented as described.
- ALU_MULDIV_EN undefined: the muldiv engine is not instantiated. MUL/DIV/MOD behave as NOP (rdy after one cycle, outputs unchanged) and set no flags.

## Structure
- Package alu_pkg holds:
  - opcode localparams: ADD=1, SUB=2, LSR=3, LSL=4, RSR=5, RSL=6, MUL=7, DIV=8, MOD=9, AND=10, OR=11, XOR=12, NOT=13, CMP=14, TST=15, INC=16, DEC=17, NOP=31.
  - state encoding: IDLE, EXEC, DONE.
  - a helper function for signed overflow.
- Sub-module alu_muldiv_unit, parametrised by WIDTH:
  - iterative shift-add/restoring engine with its own start/done and counter.
  - instantiated only under ALU_MULDIV_EN.
- The top module holds the FSM, single-cycle datapath, rotator and flag logic.

## Test plan
- WIDTH=16, ADD A=16'h7FFF, B=16'h0001 -> after 1 cycle: acc1=16'h8000, acc2=0, overflow=1, negative=1, carry=0, zero=0, single rdy pulse.
- SUB A=3, B=5 -> acc1=16'hFFFE, carry=1, negative=1. Then CMP A=5, B=5 -> zero=1 and acc1 still 16'hFFFE.
- RSL A=16'h8001, B=20 (k=4) -> rdy after 5 cycles, acc1=16'h0018. RSR with B=0 -> acc1=A after 1 cycle.
- MUL A=16'hFFFF, B=16'hFFFF -> rdy after 17 cycles: acc2=16'hFFFE, acc1=16'h0001. With ALU_MULDIV_EN undefined -> rdy after 1 cycle, outputs unchanged.
- DIV A=100, B=7 -> acc1=14, acc2=2 after 17 cycles. DIV B=0 -> acc1=16'hFFFF, acc2=100, overflow=1 after 1 cycle.
- MUL started, rst_n=0 at EXEC cycle 5 -> next cycle all outputs 0, no rdy. bgn pulsed while busy -> ignored, exactly one rdy.
